// File: rtl/regfile_wb_controller.sv
// Register file writeback controller: arbitrates ALU and LSU writebacks onto the
// single write port, bounds ALU starvation, and tracks pending destinations.
module regfile_wb_controller #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int NUM_REGISTER = 32,
  parameter  int STARVE_LIMIT = 4,
  localparam int AW           = $clog2(NUM_REGISTER),
  localparam int CW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  issue_valid_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  issue_ready_o,

  input  logic                  alu_valid_i,
  input  logic [AW-1:0]         alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,

  input  logic                  lsu_valid_i,
  input  logic [AW-1:0]         lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,

  input  logic [AW-1:0]         rs1_addr_i,
  input  logic [AW-1:0]         rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,

  output logic                  we_o,
  output logic [AW-1:0]         rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_o
);

  logic [CW-1:0]           starve_cnt_p0;
  logic [CW-1:0]           starve_cnt_nxt;
  logic                    alu_force;
  logic                    alu_gnt;
  logic                    lsu_gnt;

  logic                    vld_p1;
  logic [AW-1:0]           rd_addr_p1;
  logic [DATA_WIDTH-1:0]   rd_p1;

  logic [NUM_REGISTER-1:0] busy_q;
  logic [NUM_REGISTER-1:0] busy_nxt;
  logic [NUM_REGISTER-1:0] set_vec;
  logic [NUM_REGISTER-1:0] clr_vec;
  logic                    issue_hs;

  localparam logic [NUM_REGISTER-1:0] ONE_HOT0 = {{(NUM_REGISTER-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt == CW'(STARVE_LIMIT)) sat_inc = cnt;
    else                          sat_inc = cnt + CW'(1);
  endfunction

  // Guarded lookup so non-power-of-two register counts never read past the vector.
  function automatic logic busy_at(input logic [NUM_REGISTER-1:0] vec,
                                   input logic [AW-1:0]           addr);
    if ({1'b0, addr} < (AW+1)'(NUM_REGISTER)) busy_at = vec[addr];
    else                                      busy_at = 1'b0;
  endfunction

  // Stage p0: arbitration, LSU wins unless the ALU has been starved to the limit
  always_comb begin
    alu_force   = (starve_cnt_p0 == CW'(STARVE_LIMIT));
    lsu_ready_o = lsu_valid_i && !alu_force;
    alu_ready_o = alu_valid_i && (!lsu_valid_i || alu_force);
    alu_gnt     = alu_ready_o;
    lsu_gnt     = lsu_ready_o;
  end

  always_comb begin
    starve_cnt_nxt = '0;
    if (alu_valid_i && !alu_ready_o) starve_cnt_nxt = sat_inc(starve_cnt_p0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_p0 <= '0;
    else       starve_cnt_p0 <= starve_cnt_nxt;
  end

  // Stage p1: registered write port; address and data hold when nothing is granted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      rd_addr_p1 <= '0;
      rd_p1      <= '0;
    end else if (alu_gnt) begin
      vld_p1     <= (alu_rd_i != '0);
      rd_addr_p1 <= alu_rd_i;
      rd_p1      <= alu_data_i;
    end else if (lsu_gnt) begin
      vld_p1     <= (lsu_rd_i != '0);
      rd_addr_p1 <= lsu_rd_i;
      rd_p1      <= lsu_data_i;
    end else begin
      vld_p1     <= 1'b0;
    end
  end

  assign we_o      = vld_p1;
  assign rd_addr_o = rd_addr_p1;
  assign rd_o      = rd_p1;

  // Scoreboard: issue sets at the handshake edge, the p1 write clears at its own edge
  always_comb begin
    issue_ready_o = !busy_at(busy_q, issue_rd_i);
    issue_hs      = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
    set_vec       = issue_hs ? (ONE_HOT0 << issue_rd_i) : '0;
    clr_vec       = vld_p1   ? (ONE_HOT0 << rd_addr_p1) : '0;
    busy_nxt      = (busy_q & ~clr_vec) | set_vec;
    busy_nxt[0]   = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign rs1_busy_o = busy_at(busy_q, rs1_addr_i);
  assign rs2_busy_o = busy_at(busy_q, rs2_addr_i);

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Directed bench for regfile_wb_controller: expected register-file writes are queued
// at grant time and matched by a monitor against the write port.
module tb_regfile_wb_controller;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_busy, rs2_busy;
  logic          we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_controller #(.DATA_WIDTH(DW), .NUM_REGISTER(NR), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .we_o(we), .rd_addr_o(rd_addr), .rd_o(rd)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, rd_addr, 32'd0}, 64'd0);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("wb_addr", rd_addr, e[AW+DW-1:DW]);
        chk("wb_data", rd, e[DW-1:0]);
      end
    end
  end

  initial begin
    logic [NR-1:0] sweep;
    int l;
    rst = 1'b1;
    issue_valid = 0; issue_rd = 0;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h0000_A1A1;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h2222_0000;
    rs1_addr = 0; rs2_addr = 0;

    // Reset held two cycles with both sources valid
    tick(); tick();
    rst = 1'b0;
    chk("rst_we", we, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rd_addr", rd_addr, 0);
    for (int r = 0; r < NR; r++) begin
      rs1_addr = AW'(r);
      #1;
      sweep[r] = rs1_busy;
    end
    chk("rst_busy_all", sweep, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_alu_ready", alu_ready, 0);
    push(5'd2, 32'h2222_0000);
    tick();
    alu_valid = 0; lsu_valid = 0;
    tick();

    // Single LSU write
    lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'hDEADBEEF;
    #1;
    chk("lsu_single_ready", lsu_ready, 1);
    push(5'd5, 32'hDEADBEEF);
    tick();
    lsu_valid = 0;
    #1;
    chk("lsu_single_we", we, 1);
    chk("lsu_single_addr", rd_addr, 5);
    chk("lsu_single_data", rd, 32'hDEADBEEF);
    tick();
    chk("lsu_single_we_off", we, 0);

    // Starvation: LSU streams continuously, ALU rd=7 waits 4 cycles
    l = 0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
    lsu_valid = 1; lsu_rd = 5'd10;
    for (int c = 0; c < 6; c++) begin
      lsu_data = 32'h1000 + l;
      if (c == 5) alu_valid = 0;
      #1;
      chk($sformatf("starve_alu_ready_c%0d", c), alu_ready, (c == 4));
      chk($sformatf("starve_lsu_ready_c%0d", c), lsu_ready, (c != 4));
      if (c == 4) push(5'd7, 32'h77);
      else begin
        push(5'd10, 32'h1000 + l);
        l++;
      end
      tick();
    end
    lsu_valid = 0;
    tick();

    // Scoreboard round trip on rd=3
    issue_valid = 1; issue_rd = 5'd3; rs1_addr = 5'd3;
    #1;
    chk("sb_issue_ready_c0", issue_ready, 1);
    chk("sb_busy_c0", rs1_busy, 0);
    tick();
    chk("sb_busy_c1", rs1_busy, 1);
    chk("sb_reissue_refused", issue_ready, 0);
    issue_valid = 0;
    tick(); tick(); tick();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    #1;
    chk("sb_alu_ready_c4", alu_ready, 1);
    push(5'd3, 32'h33);
    tick();
    alu_valid = 0;
    #1;
    chk("sb_busy_c5", rs1_busy, 1);
    tick();
    issue_valid = 1; issue_rd = 5'd3;
    #1;
    chk("sb_busy_c6", rs1_busy, 0);
    chk("sb_issue_again", issue_ready, 1);
    tick();
    issue_valid = 0;
    chk("sb_busy_reset_again", rs1_busy, 1);

    // x0 handling
    issue_valid = 1; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 0;
    #1;
    chk("x0_rs1_busy", rs1_busy, 0);
    chk("x0_rs2_busy", rs2_busy, 0);
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h0000_0ABC;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    chk("x0_we", we, 0);
    tick();

    // Simultaneous set of rd=9 and clear of rd=4
    issue_valid = 1; issue_rd = 5'd4;
    #1;
    chk("sc_issue4_ready", issue_ready, 1);
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
    #1;
    chk("sc_alu4_ready", alu_ready, 1);
    push(5'd4, 32'h44);
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 5'd9; rs1_addr = 5'd4;
    #1;
    chk("sc_issue9_ready", issue_ready, 1);
    chk("sc_busy4_during_we", rs1_busy, 1);
    tick();
    issue_valid = 0; rs1_addr = 5'd9; rs2_addr = 5'd4;
    #1;
    chk("sc_busy9_set", rs1_busy, 1);
    chk("sc_busy4_clr", rs2_busy, 0);

    // Reset during a pending LSU grant with busy[9] and busy[3] set
    rst = 1; lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'h0000_1212;
    #1;
    chk("mr_lsu_ready", lsu_ready, 1);
    tick();
    rst = 0; lsu_valid = 0; rs1_addr = 5'd9; rs2_addr = 5'd3;
    #1;
    chk("mr_we", we, 0);
    chk("mr_busy9", rs1_busy, 0);
    chk("mr_busy3", rs2_busy, 0);
    tick();
    chk("mr_we_next", we, 0);
    tick(); tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
